// File: rtl/pu_msp430_pkg.sv
// pu_msp430_pkg: shared types for the msp430 peripheral slice
package pu_msp430_pkg;
  typedef enum logic [1:0] {IDLE, REQ, REL, RECOV} state_t;
endpackage

// File: rtl/pu_msp430_sync_cell.sv
// pu_msp430_sync_cell: two-flop synchronizer for a single asynchronous bit
module pu_msp430_sync_cell (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk or posedge rst)
    if (rst) {q, m} <= 2'b00;
    else     {q, m} <= {m, d};
endmodule

// File: rtl/pu_msp430_cdc_tx.sv
// pu_msp430_cdc_tx: 4-phase request/ack word transmitter with timeout recovery
module pu_msp430_cdc_tx
  import pu_msp430_pkg::*;
#(
  parameter int DW     = 16,
  parameter int TO_CYC = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          src_valid,
  input  logic [DW-1:0] src_data,
  output logic          src_ready,
  output logic          xfer_req,
  output logic [DW-1:0] xfer_data,
  input  logic          xfer_ack,
  output logic          done,
  output logic          err,
  output logic          busy
);
  localparam int CW = $clog2(TO_CYC + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TO_CYC - 1);
  localparam logic [CW-1:0] TO_MAX  = CW'(TO_CYC);
  state_t        state;
  logic [CW-1:0] cnt;
  logic          ack_s, low1;
  pu_msp430_sync_cell u_sync (.clk(clk), .rst(rst), .d(xfer_ack), .q(ack_s));
  assign src_ready = (state == IDLE) && !ack_s;
  // Timeout fires on the cycle the counter would reach TO_CYC, so REQ/REL last at most TO_CYC cycles
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      xfer_req  <= 1'b0;
      xfer_data <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      cnt       <= '0;
      low1      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE:
          if (src_valid && src_ready) begin
            xfer_data <= src_data;
            xfer_req  <= 1'b1;
            busy      <= 1'b1;
            state     <= REQ;
            cnt       <= '0;
          end
        REQ:
          if (ack_s) begin
            xfer_req <= 1'b0;
            state    <= REL;
            cnt      <= '0;
          end else if (cnt == TO_LAST) begin
            xfer_req <= 1'b0;
            err      <= 1'b1;
            state    <= RECOV;
            cnt      <= '0;
            low1     <= 1'b0;
          end else cnt <= cnt + 1'b1;
        REL:
          if (!ack_s) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == TO_LAST) begin
            err   <= 1'b1;
            state <= RECOV;
            cnt   <= '0;
            low1  <= 1'b0;
          end else cnt <= cnt + 1'b1;
        RECOV: begin
          // leave only after the destination has shown ack low twice in a row
          low1 <= !ack_s;
          if (!ack_s && low1) begin
            busy  <= 1'b0;
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt != TO_MAX) cnt <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_pu_msp430_cdc_tx.sv
// tb_pu_msp430_cdc_tx: directed vector bench for the CDC transmitter
module tb_pu_msp430_cdc_tx;
  logic        clk = 0, rst = 1, src_valid = 0, xfer_ack = 0;
  logic [15:0] src_data = 0;
  logic        src_ready, xfer_req, done, err, busy;
  logic [15:0] xfer_data;
  int          nvec = 0, nbad = 0;

  pu_msp430_cdc_tx #(.DW(16), .TO_CYC(8)) dut (
    .clk(clk), .rst(rst), .src_valid(src_valid), .src_data(src_data),
    .src_ready(src_ready), .xfer_req(xfer_req), .xfer_data(xfer_data),
    .xfer_ack(xfer_ack), .done(done), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    int          up;
    int          dn;
    int          k;
    logic        ok;
  } vec_t;
  vec_t tv[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // called on a falling edge; returns on the falling edge right after the accepting edge
  task automatic accept(input logic [15:0] d);
    chk("ready_pre", src_ready, 1);
    src_valid = 1;
    src_data  = d;
    @(negedge clk);
    src_valid = 0;
    chk("req_rise", xfer_req, 1);
    chk("data_load", xfer_data, d);
    chk("busy_rise", busy, 1);
    chk("ready_busy", src_ready, 0);
  endtask

  logic [15:0] words[3];
  int nd, ne, kp, lo, nacc;
  logic acc;

  initial begin
    // ack rises k cycles after req is first seen (255 = never); drops dn cycles after req falls
    tv[0] = '{16'hA5C3, 1, 1, 8, 1'b1};
    tv[1] = '{16'h1234, 0, 0, 6, 1'b1};
    tv[2] = '{16'hFFFF, 2, 0, 8, 1'b1};
    tv[3] = '{16'h0001, 0, 3, 9, 1'b1};
    tv[4] = '{16'h5A5A, 5, 0, 11, 1'b1};
    tv[5] = '{16'h8000, 255, 0, 8, 1'b0};
    tv[6] = '{16'hC0DE, 6, 0, 8, 1'b0};
    tv[7] = '{16'hBEEF, 0, 5, 11, 1'b1};
    tv[8] = '{16'h7E57, 0, 6, 11, 1'b0};
    words[0] = 16'h1111;
    words[1] = 16'h2222;
    words[2] = 16'h3333;

    @(negedge clk);
    @(negedge clk);
    chk("rst_req", xfer_req, 0);
    chk("rst_data", xfer_data, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", src_ready, 1);
    rst = 0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      nd = 0; ne = 0; kp = -1; lo = 0;
      accept(tv[i].data);
      for (int k = 0; k < 20; k++) begin
        if (k > 0) @(negedge clk);
        chk("excl", done & err, 0);
        if ((done || err) && kp < 0) kp = k;
        nd += int'(done);
        ne += int'(err);
        if (busy) chk("hold", xfer_data, tv[i].data);
        if (k == tv[i].up) xfer_ack = 1;
        else if (xfer_ack && !xfer_req) begin
          if (lo >= tv[i].dn) xfer_ack = 0;
          else lo++;
        end
      end
      chk("pulse_cyc", kp, tv[i].k);
      chk("done_cnt", nd, tv[i].ok ? 1 : 0);
      chk("err_cnt", ne, tv[i].ok ? 0 : 1);
      chk("end_busy", busy, 0);
      chk("end_req", xfer_req, 0);
      chk("end_ready", src_ready, 1);
    end

    // back-to-back words with an immediate destination
    nd = 0; nacc = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) begin
        if (nd < 3) chk("b2b_order", xfer_data, words[nd]);
        nd++;
      end
      xfer_ack  = xfer_req;
      src_valid = nacc < 3;
      if (nacc < 3) src_data = words[nacc];
      acc = src_ready && src_valid;
      @(negedge clk);
      if (acc) begin
        nacc++;
        chk("b2b_ready_low", src_ready, 0);
      end
    end
    src_valid = 0;
    xfer_ack  = 0;
    chk("b2b_accepts", nacc, 3);
    chk("b2b_dones", nd, 3);
    repeat (3) @(negedge clk);

    // ack stuck high after req drops: timeout in REL, held in RECOV until ack falls
    nd = 0; ne = 0; kp = -1;
    accept(16'h0F0F);
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      if (err && kp < 0) kp = k;
      nd += int'(done);
      ne += int'(err);
      if (k == 0) xfer_ack = 1;
      if (k == 15) xfer_ack = 0;
      if (k == 4) chk("stuck_rel_req", xfer_req, 0);
      if (k == 14) chk("stuck_recov_busy", busy, 1);
      if (k == 18) chk("stuck_recov_hold", busy, 1);
      if (k == 19) chk("stuck_idle", busy, 0);
    end
    chk("stuck_err_cyc", kp, 11);
    chk("stuck_err_cnt", ne, 1);
    chk("stuck_no_done", nd, 0);
    chk("stuck_ready", src_ready, 1);

    // spurious ack while idle
    xfer_ack = 1;
    repeat (3) @(negedge clk);
    chk("spur_ready", src_ready, 0);
    chk("spur_busy", busy, 0);
    src_valid = 1;
    src_data  = 16'hDEAD;
    repeat (2) @(negedge clk);
    chk("spur_ignore_busy", busy, 0);
    chk("spur_ignore_req", xfer_req, 0);
    src_valid = 0;
    xfer_ack  = 0;
    repeat (3) @(negedge clk);
    chk("spur_recover", src_ready, 1);

    // reset during REL
    nd = 0;
    accept(16'h3C3C);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      nd += int'(done);
      if (k == 0) xfer_ack = 1;
    end
    chk("mid_data_pre", xfer_data, 16'h3C3C);
    chk("mid_busy_pre", busy, 1);
    rst = 1;
    #1;
    chk("mid_req", xfer_req, 0);
    chk("mid_data", xfer_data, 0);
    chk("mid_busy", busy, 0);
    @(negedge clk);
    nd += int'(done);
    rst = 0;
    repeat (3) begin
      @(negedge clk);
      nd += int'(done);
    end
    chk("mid_ready_ack", src_ready, 0);
    chk("mid_no_reissue", busy, 0);
    xfer_ack = 0;
    repeat (3) begin
      @(negedge clk);
      nd += int'(done);
    end
    chk("mid_ready_end", src_ready, 1);
    chk("mid_no_done", nd, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
